// File: rtl/matrix_pool2d.sv
// matrix_pool2d: windowed max/average pooling over channel-stacked row-major planes.
// Average pooling is only built when POOL_AVG_MODE_EN is defined; otherwise max pooling is used.
module matrix_pool2d #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int DIM_W  = 10,
  parameter int WIN_W  = 4,
  parameter int CH_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     done,
  output logic                     err,
  input  logic                     mode,
  input  logic [ADDR_W-1:0]        src_start_address,
  output logic [ADDR_W-1:0]        src_address,
  input  logic signed [DATA_W-1:0] src_readdata,
  output logic                     src_write_en,
  input  logic [DIM_W-1:0]         in_rows,
  input  logic [DIM_W-1:0]         in_cols,
  input  logic [WIN_W-1:0]         win_rows,
  input  logic [WIN_W-1:0]         win_cols,
  input  logic [WIN_W-1:0]         stride,
  input  logic [CH_W-1:0]          channels,
  input  logic [4:0]               avg_shift,
  input  logic [ADDR_W-1:0]        dest_start_address,
  output logic [ADDR_W-1:0]        dest_address,
  output logic signed [DATA_W-1:0] dest_writedata,
  output logic                     dest_write_en
);

  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETUP, FETCH, DRAIN, WRITE} state_t;
  state_t state;

  logic [ADDR_W-1:0] src_base_q, dest_base_q;
  logic [DIM_W-1:0]  in_rows_q, in_cols_q;
  logic [WIN_W-1:0]  win_r_q, win_c_q, stride_q;
  logic [CH_W-1:0]   ch_q;

  logic [ADDR_W-1:0] plane_ptr, orow_ptr, win_ptr, row_ptr;
  logic [DIM_W-1:0]  top_r, left_c;
  logic [WIN_W-1:0]  wr, wc;
  logic [CH_W-1:0]   ch;
  logic              take;
  logic signed [DATA_W-1:0] acc_max, max_next, result;

  assign src_write_en = 1'b0;

  logic [ADDR_W-1:0] rows_a, cols_a, stride_a, plane_sz, row_step;
  assign rows_a   = ADDR_W'(in_rows_q);
  assign cols_a   = ADDR_W'(in_cols_q);
  assign stride_a = ADDR_W'(stride_q);
  assign plane_sz = rows_a * cols_a;
  assign row_step = stride_a * cols_a;

  logic invalid, last_wc, last_wr, more_col, more_row, more_ch;
  assign invalid = (in_rows_q == '0) || (in_cols_q == '0) || (win_r_q == '0) ||
                   (win_c_q == '0) || (stride_q == '0) || (ch_q == '0) ||
                   (DIM_W'(win_r_q) > in_rows_q) || (DIM_W'(win_c_q) > in_cols_q);
  assign last_wc = (wc == win_c_q - WIN_W'(1));
  assign last_wr = (wr == win_r_q - WIN_W'(1));
  // Edge tests replace the out_r/out_c floor divisions: another window fits iff its far edge stays inside.
  assign more_col = ({1'b0, left_c} + (DIM_W+1)'(stride_q) + (DIM_W+1)'(win_c_q)) <= {1'b0, in_cols_q};
  assign more_row = ({1'b0, top_r} + (DIM_W+1)'(stride_q) + (DIM_W+1)'(win_r_q)) <= {1'b0, in_rows_q};
  assign more_ch  = (ch != ch_q - CH_W'(1));

  logic [ADDR_W-1:0] col_ptr_n, row_ptr_n, plane_ptr_n;
  assign col_ptr_n   = win_ptr + stride_a;
  assign row_ptr_n   = orow_ptr + row_step;
  assign plane_ptr_n = plane_ptr + plane_sz;

  always_comb begin
    max_next = acc_max;
    if (take && (src_readdata > acc_max)) max_next = src_readdata;
  end

`ifdef POOL_AVG_MODE_EN
  localparam int SUM_W = DATA_W + 2*WIN_W;
  logic                    mode_q;
  logic [4:0]              shift_q;
  logic signed [SUM_W-1:0] acc_sum, sum_next;
  always_comb begin
    sum_next = acc_sum;
    if (take) sum_next = acc_sum + SUM_W'(src_readdata);
    result = mode_q ? DATA_W'(sum_next >>> shift_q) : max_next;
  end
`else
  logic unused_avg_cfg;
  assign unused_avg_cfg = ^{mode, avg_shift};
  assign result = max_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      done           <= 1'b1;
      err            <= 1'b0;
      dest_write_en  <= 1'b0;
      src_address    <= src_start_address;
      dest_address   <= dest_start_address;
      dest_writedata <= '0;
      wr <= '0; wc <= '0; ch <= '0; top_r <= '0; left_c <= '0;
      take <= 1'b0; acc_max <= '0;
      plane_ptr <= '0; orow_ptr <= '0; win_ptr <= '0; row_ptr <= '0;
      src_base_q <= '0; dest_base_q <= '0; in_rows_q <= '0; in_cols_q <= '0;
      win_r_q <= '0; win_c_q <= '0; stride_q <= '0; ch_q <= '0;
`ifdef POOL_AVG_MODE_EN
      acc_sum <= '0; mode_q <= 1'b0; shift_q <= '0;
`endif
    end else begin
      take          <= (state == FETCH);
      dest_write_en <= 1'b0;
      acc_max       <= max_next;
`ifdef POOL_AVG_MODE_EN
      acc_sum       <= sum_next;
`endif
      case (state)
        IDLE: if (start) begin
          src_base_q  <= src_start_address;
          dest_base_q <= dest_start_address;
          in_rows_q   <= in_rows;
          in_cols_q   <= in_cols;
          win_r_q     <= win_rows;
          win_c_q     <= win_cols;
          stride_q    <= stride;
          ch_q        <= channels;
`ifdef POOL_AVG_MODE_EN
          mode_q      <= mode;
          shift_q     <= avg_shift;
`endif
          done  <= 1'b0;
          err   <= 1'b0;
          state <= SETUP;
        end
        SETUP: if (invalid) begin
          err   <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
        end else begin
          plane_ptr <= src_base_q; orow_ptr <= src_base_q; win_ptr <= src_base_q;
          row_ptr <= src_base_q; src_address <= src_base_q;
          dest_address <= dest_base_q;
          wr <= '0; wc <= '0; ch <= '0; top_r <= '0; left_c <= '0;
          acc_max <= MIN_VAL;
`ifdef POOL_AVG_MODE_EN
          acc_sum <= '0;
`endif
          state <= FETCH;
        end
        FETCH: begin
          if (!last_wc) begin
            wc          <= wc + WIN_W'(1);
            src_address <= src_address + ADDR_W'(1);
          end else if (!last_wr) begin
            wc          <= '0;
            wr          <= wr + WIN_W'(1);
            row_ptr     <= row_ptr + cols_a;
            src_address <= row_ptr + cols_a;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          dest_writedata <= result;
          dest_write_en  <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          dest_address <= dest_address + ADDR_W'(1);
          wr <= '0; wc <= '0;
          acc_max <= MIN_VAL;
`ifdef POOL_AVG_MODE_EN
          acc_sum <= '0;
`endif
          if (more_col) begin
            left_c  <= left_c + DIM_W'(stride_q);
            win_ptr <= col_ptr_n; row_ptr <= col_ptr_n; src_address <= col_ptr_n;
            state   <= FETCH;
          end else if (more_row) begin
            left_c   <= '0;
            top_r    <= top_r + DIM_W'(stride_q);
            orow_ptr <= row_ptr_n; win_ptr <= row_ptr_n; row_ptr <= row_ptr_n;
            src_address <= row_ptr_n;
            state    <= FETCH;
          end else if (more_ch) begin
            ch <= ch + CH_W'(1); top_r <= '0; left_c <= '0;
            plane_ptr <= plane_ptr_n; orow_ptr <= plane_ptr_n; win_ptr <= plane_ptr_n;
            row_ptr <= plane_ptr_n; src_address <= plane_ptr_n;
            state <= FETCH;
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_pool2d.sv
// Bench for matrix_pool2d: directed jobs plus random jobs checked against a window-by-window reference model.
module tb_matrix_pool2d;
  localparam int DW = 16, AW = 14, MW = 10, WW = 4, CW = 4;
  localparam int AMASK = (1 << AW) - 1;
`ifdef POOL_AVG_MODE_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, done, err, mode, src_write_en, dest_write_en;
  logic [AW-1:0] src_start_address, src_address, dest_start_address, dest_address;
  logic signed [DW-1:0] src_readdata, dest_writedata;
  logic [MW-1:0] in_rows, in_cols;
  logic [WW-1:0] win_rows, win_cols, stride;
  logic [CW-1:0] channels;
  logic [4:0] avg_shift;

  matrix_pool2d #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(MW), .WIN_W(WW), .CH_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .err(err), .mode(mode),
    .src_start_address(src_start_address), .src_address(src_address),
    .src_readdata(src_readdata), .src_write_en(src_write_en),
    .in_rows(in_rows), .in_cols(in_cols), .win_rows(win_rows), .win_cols(win_cols),
    .stride(stride), .channels(channels), .avg_shift(avg_shift),
    .dest_start_address(dest_start_address), .dest_address(dest_address),
    .dest_writedata(dest_writedata), .dest_write_en(dest_write_en)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) src_readdata <= mem[src_address];

  logic [AW-1:0]        wa_q[$];
  logic signed [DW-1:0] wd_q[$];
  logic signed [DW-1:0] exp_q[$];
  always @(negedge clk)
    if (dest_write_en === 1'b1) begin
      wa_q.push_back(dest_address);
      wd_q.push_back(dest_writedata);
    end

  int checks = 0, errors = 0;
  int cur_db, cur_exp_cyc;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pooling computed directly from the mathematical definition of each output window.
  function automatic void model(input int ir, ic, wrr, wcc, st, chn, md, sh, sb);
    int orr, occ;
    exp_q.delete();
    if (ir == 0 || ic == 0 || wrr == 0 || wcc == 0 || st == 0 || chn == 0 || wrr > ir || wcc > ic) return;
    orr = (ir - wrr) / st + 1;
    occ = (ic - wcc) / st + 1;
    for (int c = 0; c < chn; c++)
      for (int r = 0; r < orr; r++)
        for (int k = 0; k < occ; k++) begin
          longint sum = 0;
          int mx = -32768;
          logic signed [DW-1:0] res;
          for (int i = 0; i < wrr; i++)
            for (int j = 0; j < wcc; j++) begin
              int a = (sb + c*ir*ic + (r*st + i)*ic + k*st + j) & AMASK;
              int v = int'(mem[a]);
              if (v > mx) mx = v;
              sum += v;
            end
          if (AVG_EN && md != 0) res = DW'(sum >>> sh);
          else res = DW'(mx);
          exp_q.push_back(res);
        end
  endfunction

  task automatic launch(input int ir, ic, wrr, wcc, st, chn, md, sh, sb, db, input bit hold);
    in_rows = MW'(ir); in_cols = MW'(ic); win_rows = WW'(wrr); win_cols = WW'(wcc);
    stride = WW'(st); channels = CW'(chn); mode = 1'(md); avg_shift = 5'(sh);
    src_start_address = AW'(sb); dest_start_address = AW'(db);
    model(ir, ic, wrr, wcc, st, chn, md, sh, sb);
    wa_q.delete(); wd_q.delete();
    cur_db = db;
    cur_exp_cyc = (exp_q.size() == 0) ? 2 : exp_q.size() * (wrr*wcc + 2) + 2;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0;
      in_rows = MW'($urandom); in_cols = MW'($urandom); win_rows = WW'($urandom);
      win_cols = WW'($urandom); stride = WW'($urandom); channels = CW'($urandom);
      mode = 1'($urandom); avg_shift = 5'($urandom);
      src_start_address = AW'($urandom); dest_start_address = AW'($urandom);
    end
  endtask

  task automatic finish_job(input string tag);
    int cyc = 1;
    int n;
    check({tag, ".busy"}, done, 0);
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".cycles"}, cyc, cur_exp_cyc);
    check({tag, ".err"}, err, (exp_q.size() == 0) ? 1 : 0);
    check({tag, ".nwrites"}, wd_q.size(), exp_q.size());
    n = (wd_q.size() < exp_q.size()) ? wd_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.data%0d", tag, i), wd_q[i], exp_q[i]);
      check($sformatf("%s.addr%0d", tag, i), wa_q[i], (cur_db + i) & AMASK);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; avg_shift = '0;
    in_rows = '0; in_cols = '0; win_rows = '0; win_cols = '0; stride = '0; channels = '0;
    src_start_address = AW'(77); dest_start_address = AW'(99);
    for (int i = 0; i <= AMASK; i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst.done", done, 1);
    check("rst.err", err, 0);
    check("rst.wen", dest_write_en, 0);
    check("rst.srcaddr", src_address, 77);
    check("rst.dstaddr", dest_address, 99);
    check("rst.wdata", dest_writedata, 0);
    check("rst.srcwen", src_write_en, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Negative-valued plane: max must not be clipped by a zero initial value.
    for (int i = 0; i < 16; i++) mem[200 + i] = DW'(-100 + i);
    launch(4, 4, 2, 2, 2, 1, 0, 0, 200, 1000, 1'b0);
    finish_job("neg4x4");
    check("neg4x4.w0", wd_q[0], -95);
    check("neg4x4.w1", wd_q[1], -93);
    check("neg4x4.w2", wd_q[2], -87);
    check("neg4x4.w3", wd_q[3], -85);

    // Two contiguous channels, overlapping windows.
    for (int i = 0; i < 25; i++) begin
      mem[300 + i] = DW'(i);
      mem[325 + i] = DW'(100 + i);
    end
    launch(5, 5, 3, 3, 1, 2, 0, 0, 300, 2000, 1'b0);
    finish_job("ch2");
    check("ch2.first", wd_q[0], 12);
    check("ch2.last", wd_q[17], 124);

    // mode=1 is average only when the feature is compiled in.
    for (int i = 0; i < 16; i++) mem[400 + i] = DW'(i);
    launch(4, 4, 2, 2, 2, 1, 1, 2, 400, 3000, 1'b0);
    finish_job("mode1");
`ifdef POOL_AVG_MODE_EN
    check("avg.w0", wd_q[0], 2);
    check("avg.w1", wd_q[1], 4);
    check("avg.w2", wd_q[2], 10);
    check("avg.w3", wd_q[3], 12);
`else
    check("maxonly.w0", wd_q[0], 5);
    check("maxonly.w3", wd_q[3], 15);
`endif

    // Window taller than the plane is rejected; err persists until the next accepted start.
    launch(4, 4, 5, 2, 1, 1, 0, 0, 200, 4000, 1'b0);
    finish_job("badwin");
    repeat (3) @(posedge clk);
    #1;
    check("badwin.errheld", err, 1);
    check("badwin.doneheld", done, 1);

    // Reset during the second window's fetch discards it.
    launch(4, 4, 2, 2, 2, 1, 0, 0, 200, 1000, 1'b0);
    begin
      int guard = 0;
      while (wd_q.size() == 0 && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
    end
    check("midrst.first", wd_q.size(), 1);
    src_start_address = AW'(55); dest_start_address = AW'(66);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst.done", done, 1);
    check("midrst.wen", dest_write_en, 0);
    check("midrst.err", err, 0);
    check("midrst.srcaddr", src_address, 55);
    check("midrst.dstaddr", dest_address, 66);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst.nowrites", wd_q.size(), 1);
    launch(4, 4, 2, 2, 2, 1, 0, 0, 200, 1000, 1'b0);
    finish_job("rerun");

    // start held high: one job, then a fresh job only once done is seen.
    launch(4, 4, 2, 2, 2, 1, 0, 0, 200, 1500, 1'b1);
    finish_job("hold1");
    wa_q.delete(); wd_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    finish_job("hold2");

    for (int t = 0; t < 12; t++) begin
      int ir = $urandom_range(1, 7);
      int ic = $urandom_range(1, 7);
      int sb = (t == 0) ? AMASK - 20 : $urandom_range(0, AMASK);
      int db = (t == 1) ? AMASK - 2 : $urandom_range(0, AMASK);
      launch(ir, ic, $urandom_range(1, ir), $urandom_range(1, ic), $urandom_range(1, 3),
             $urandom_range(1, 3), $urandom_range(0, 1), $urandom_range(0, 6), sb, db, 1'b0);
      finish_job($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
